// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the 6502 clock/reset/interrupt sequencer.
package cpu_clk_pkg;

  typedef enum logic {
    SEQ_HOLD = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef enum logic [1:0] {
    NMI_IDLE  = 2'd0,
    NMI_ARMED = 2'd1,
    NMI_PULSE = 2'd2
  } nmi_state_t;

  localparam int DEF_PHI_HALF    = 10;
  localparam int DEF_RES_CYCLES  = 5;
  localparam int DEF_N_IRQ       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_NMI_PHI     = 2;

  // Never returns less than 1 so it can size a vector directly.
  function automatic int CLOG2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-bit flop-chain synchroniser for asynchronous inputs.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         res,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cpu_clock_reset_gen.sv
// Drives phi, cpu_res_n, irq_n, nmi_n and rdy of a chip_6502 core from clk.
// CPU-facing irq/nmi/rdy levels only change on phi-fall edges.
//   state     | meaning
//   SEQ_HOLD  | cpu_res_n low, counting RES_CYCLES phi falls
//   SEQ_RUN   | CPU running, irq/nmi/rdy follow their sources
//   NMI_IDLE  | no NMI request outstanding
//   NMI_ARMED | edge captured, waiting for the next phi fall
//   NMI_PULSE | nmi_n low until NMI_PHI phi falls have passed
module cpu_clock_reset_gen
  import cpu_clk_pkg::*;
#(
  parameter int PHI_HALF    = DEF_PHI_HALF,
  parameter int RES_CYCLES  = DEF_RES_CYCLES,
  parameter int N_IRQ       = DEF_N_IRQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NMI_PHI     = DEF_NMI_PHI
) (
  input  logic             clk,
  input  logic             res,
  input  logic             soft_res,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             nmi_src,
  input  logic             rdy_in,
  output logic             phi,
  output logic             phi_rise,
  output logic             phi_fall,
  output logic             cpu_res_n,
  output logic             irq_n,
  output logic             nmi_n,
  output logic             rdy,
  output logic [N_IRQ-1:0] irq_pending
);

  localparam int CW = CLOG2(PHI_HALF);
  localparam int HW = CLOG2(RES_CYCLES + 1);
  localparam int NW = CLOG2(NMI_PHI + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PHI_HALF - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RES_CYCLES);
  localparam logic [NW-1:0] NMI_LOAD  = NW'(NMI_PHI);

  logic [CW-1:0]    div_cnt;
  logic             toggle, fall_now;
  seq_state_t       seq_state, seq_next;
  nmi_state_t       nmi_state, nmi_next;
  logic [HW-1:0]    hold_cnt, hold_next;
  logic [NW-1:0]    nmi_cnt, nmi_cnt_next;
  logic             res_n_next, irq_n_next, nmi_n_next, rdy_next;
  logic [N_IRQ-1:0] irq_sync;
  logic             nmi_sync, nmi_prev, nmi_edge, rdy_sync;

  sync_ff #(.STAGES(SYNC_STAGES), .W(N_IRQ)) u_sync_irq (
    .clk(clk), .res(res), .d(irq_src), .q(irq_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .W(1)) u_sync_nmi (
    .clk(clk), .res(res), .d(nmi_src), .q(nmi_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .W(1)) u_sync_rdy (
    .clk(clk), .res(res), .d(rdy_in), .q(rdy_sync)
  );

  assign toggle   = (div_cnt == CNT_LAST);
  assign fall_now = toggle & phi;
  assign nmi_edge = nmi_sync & ~nmi_prev;

  // The divider never sees soft_res, so phi keeps running through a soft reset.
  always_ff @(posedge clk) begin
    if (res) begin
      div_cnt     <= '0;
      phi         <= 1'b0;
      phi_rise    <= 1'b0;
      phi_fall    <= 1'b0;
      nmi_prev    <= 1'b0;
      irq_pending <= '0;
    end else begin
      div_cnt     <= toggle ? '0 : div_cnt + 1'b1;
      if (toggle) phi <= ~phi;
      phi_rise    <= toggle & ~phi;
      phi_fall    <= fall_now;
      nmi_prev    <= nmi_sync;
      irq_pending <= irq_sync & irq_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      seq_state <= SEQ_HOLD;
      hold_cnt  <= HOLD_LOAD;
      nmi_state <= NMI_IDLE;
      nmi_cnt   <= '0;
      cpu_res_n <= 1'b0;
      irq_n     <= 1'b1;
      nmi_n     <= 1'b1;
      rdy       <= 1'b1;
    end else begin
      seq_state <= seq_next;
      hold_cnt  <= hold_next;
      nmi_state <= nmi_next;
      nmi_cnt   <= nmi_cnt_next;
      cpu_res_n <= res_n_next;
      irq_n     <= irq_n_next;
      nmi_n     <= nmi_n_next;
      rdy       <= rdy_next;
    end
  end

  always_comb begin
    seq_next     = seq_state;
    hold_next    = hold_cnt;
    nmi_next     = nmi_state;
    nmi_cnt_next = nmi_cnt;
    res_n_next   = cpu_res_n;
    irq_n_next   = irq_n;
    nmi_n_next   = nmi_n;
    rdy_next     = rdy;

    case (seq_state)
      SEQ_HOLD: begin
        res_n_next   = 1'b0;
        irq_n_next   = 1'b1;
        nmi_n_next   = 1'b1;
        rdy_next     = 1'b1;
        nmi_next     = NMI_IDLE;
        nmi_cnt_next = '0;
        if (soft_res) begin
          hold_next = HOLD_LOAD;
        end else if (fall_now) begin
          if (hold_cnt <= HW'(1)) begin
            seq_next   = SEQ_RUN;
            hold_next  = '0;
            res_n_next = 1'b1;
          end else begin
            hold_next = hold_cnt - 1'b1;
          end
        end
      end

      SEQ_RUN: begin
        if (soft_res) begin
          seq_next     = SEQ_HOLD;
          hold_next    = HOLD_LOAD;
          res_n_next   = 1'b0;
          irq_n_next   = 1'b1;
          nmi_n_next   = 1'b1;
          rdy_next     = 1'b1;
          nmi_next     = NMI_IDLE;
          nmi_cnt_next = '0;
        end else begin
          if (fall_now) begin
            irq_n_next = ~|irq_pending;
            rdy_next   = rdy_sync;
          end
          case (nmi_state)
            NMI_IDLE: begin
              if (nmi_edge) nmi_next = NMI_ARMED;
            end
            NMI_ARMED: begin
              if (fall_now) begin
                nmi_next     = NMI_PULSE;
                nmi_cnt_next = NMI_LOAD;
                nmi_n_next   = 1'b0;
              end
            end
            NMI_PULSE: begin
              if (fall_now) begin
                if (nmi_cnt <= NW'(1)) begin
                  // An edge landing on the closing fall starts the next request.
                  nmi_next     = nmi_edge ? NMI_ARMED : NMI_IDLE;
                  nmi_cnt_next = '0;
                  nmi_n_next   = 1'b1;
                end else begin
                  nmi_cnt_next = nmi_cnt - 1'b1;
                end
              end
            end
            default: begin
              nmi_next   = NMI_IDLE;
              nmi_n_next = 1'b1;
            end
          endcase
        end
      end

      default: seq_next = SEQ_HOLD;
    endcase
  end

endmodule
